// File: rtl/br_unit.sv
// rtl/br_unit.sv - LC-3 branch resolution and program counter stage
//
// Purpose:
//   Owns the PC register and resolves BR instructions with a three-state
//   sequencer (IDLE -> EVAL -> UPDATE). In IDLE the PC follows the fetch
//   increment / bus load requests; a branch request latches the cond and
//   offset9 fields, EVAL registers BEN from the condition codes, and UPDATE
//   redirects the PC when BEN is set while pulsing br_done for one cycle.
//
// Optional feature:
//   BR_STATS_EN - when defined, taken_cnt counts taken branches (saturating,
//                 cleared only by reset). When undefined taken_cnt is 0.
//
// Ports:
//   clk        in   1   system clock, rising edge
//   rst_n      in   1   synchronous active-low reset
//   NZP_val    in   3   registered condition codes {N,Z,P}
//   IR         in  16   current instruction (cond = [11:9], offset9 = [8:0])
//   BUS        in  16   datapath bus, PC load source
//   br_start   in   1   resolve a BR instruction (accepted in IDLE only)
//   pc_inc     in   1   fetch increment request (IDLE only)
//   pc_ld_bus  in   1   load PC from BUS, wins over pc_inc (IDLE only)
//   PC         out 16   program counter
//   BEN        out  1   registered branch enable
//   br_busy    out  1   sequencer not in IDLE
//   br_done    out  1   one-cycle completion pulse (UPDATE state)
//   taken_cnt  out 16   taken-branch count

module br_unit #(
    parameter logic [15:0] RESET_PC = 16'h3000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  NZP_val,
    input  logic [15:0] IR,
    input  logic [15:0] BUS,
    input  logic        br_start,
    input  logic        pc_inc,
    input  logic        pc_ld_bus,
    output logic [15:0] PC,
    output logic        BEN,
    output logic        br_busy,
    output logic        br_done,
    output logic [15:0] taken_cnt
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EVAL   = 2'd1,
        S_UPDATE = 2'd2
    } state_t;

    state_t      state_q;
    logic [15:0] pc_q;
    logic        ben_q;
    logic [2:0]  cond_q;
    logic [8:0]  offset_q;

    logic [15:0] pc_target_d;
    logic        unused_ir;

    // Opcode bits are decoded by the main control FSM, not here.
    assign unused_ir = ^IR[15:12];

    // Branch target: PC plus sign-extended offset9, wrapping at 16 bits.
    assign pc_target_d = pc_q + {{7{offset_q[8]}}, offset_q};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            ben_q    <= 1'b0;
            cond_q   <= 3'b000;
            offset_q <= 9'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // PC requests are honoured even in the cycle a branch is
                    // accepted, so the target is based on the updated PC.
                    if (pc_ld_bus) begin
                        pc_q <= BUS;
                    end else if (pc_inc) begin
                        pc_q <= pc_q + 16'd1;
                    end
                    if (br_start) begin
                        cond_q   <= IR[11:9];
                        offset_q <= IR[8:0];
                        state_q  <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    // Condition codes are only looked at here.
                    ben_q   <= |(cond_q & NZP_val);
                    state_q <= S_UPDATE;
                end
                S_UPDATE: begin
                    if (ben_q) begin
                        pc_q <= pc_target_d;
                    end
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef BR_STATS_EN
    logic [15:0] taken_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            taken_cnt_q <= 16'h0000;
        end else if ((state_q == S_UPDATE) && ben_q && (taken_cnt_q != 16'hFFFF)) begin
            taken_cnt_q <= taken_cnt_q + 16'd1;
        end
    end

    assign taken_cnt = taken_cnt_q;
`else
    assign taken_cnt = 16'h0000;
`endif

    assign PC      = pc_q;
    assign BEN     = ben_q;
    assign br_busy = (state_q != S_IDLE);
    assign br_done = (state_q == S_UPDATE);

endmodule

// File: tb/tb_br_unit.sv
// tb/tb_br_unit.sv - directed self-checking bench for br_unit

module tb_br_unit;

    logic        clk;
    logic        rst_n;
    logic [2:0]  NZP_val;
    logic [15:0] IR;
    logic [15:0] BUS;
    logic        br_start;
    logic        pc_inc;
    logic        pc_ld_bus;
    logic [15:0] PC;
    logic        BEN;
    logic        br_busy;
    logic        br_done;
    logic [15:0] taken_cnt;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_cnt;

    br_unit #(.RESET_PC(16'h3000)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .NZP_val   (NZP_val),
        .IR        (IR),
        .BUS       (BUS),
        .br_start  (br_start),
        .pc_inc    (pc_inc),
        .pc_ld_bus (pc_ld_bus),
        .PC        (PC),
        .BEN       (BEN),
        .br_busy   (br_busy),
        .br_done   (br_done),
        .taken_cnt (taken_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Advance one rising edge, then settle so outputs are sampled off-edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string tag);
`ifdef BR_STATS_EN
        chk(tag, taken_cnt, exp_cnt);
`else
        chk(tag, taken_cnt, 16'h0000);
`endif
    endtask

    task automatic load_pc(input logic [15:0] v);
        pc_ld_bus = 1'b1;
        BUS = v;
        tick();
        pc_ld_bus = 1'b0;
        chk("load_pc", PC, v);
    endtask

    initial begin
        rst_n = 1'b0; NZP_val = 3'b000; IR = 16'h0000; BUS = 16'h0000;
        br_start = 1'b0; pc_inc = 1'b1; pc_ld_bus = 1'b0;
        exp_cnt = 16'h0000;

        // Reset held two cycles with pc_inc asserted
        tick(); tick();
        chk("rst_pc", PC, 16'h3000);
        chk("rst_ben", {15'd0, BEN}, 16'd0);
        chk("rst_busy", {15'd0, br_busy}, 16'd0);
        chk("rst_done", {15'd0, br_done}, 16'd0);
        chk_cnt("rst_cnt");
        rst_n = 1'b1; pc_inc = 1'b0;

        // Taken backward branch with simultaneous increment
        load_pc(16'h3005);
        NZP_val = 3'b010; IR = 16'h05FE; br_start = 1'b1; pc_inc = 1'b1;
        tick();
        br_start = 1'b0; pc_inc = 1'b0;
        chk("tb_e0_pc", PC, 16'h3006);
        chk("tb_e0_busy", {15'd0, br_busy}, 16'd1);
        chk("tb_e0_done", {15'd0, br_done}, 16'd0);
        tick();
        chk("tb_e1_ben", {15'd0, BEN}, 16'd1);
        chk("tb_e1_done", {15'd0, br_done}, 16'd1);
        chk("tb_e1_pc", PC, 16'h3006);
        tick();
        exp_cnt = 16'd1;
        chk("tb_e2_pc", PC, 16'h3004);
        chk("tb_e2_done", {15'd0, br_done}, 16'd0);
        chk("tb_e2_busy", {15'd0, br_busy}, 16'd0);
        chk_cnt("tb_e2_cnt");

        // Not taken; NZP changes outside EVAL must not matter
        load_pc(16'h3010);
        NZP_val = 3'b001; IR = 16'h0810; br_start = 1'b1;
        tick();
        br_start = 1'b0;
        tick();
        NZP_val = 3'b100;
        chk("nt_ben", {15'd0, BEN}, 16'd0);
        chk("nt_done", {15'd0, br_done}, 16'd1);
        tick();
        chk("nt_pc", PC, 16'h3010);
        chk("nt_done_off", {15'd0, br_done}, 16'd0);
        chk_cnt("nt_cnt");

        // Wrap-around and load-over-increment priority
        load_pc(16'hFFFF);
        pc_inc = 1'b1;
        tick();
        chk("wrap_pc", PC, 16'h0000);
        pc_ld_bus = 1'b1; BUS = 16'h4000;
        tick();
        pc_ld_bus = 1'b0; pc_inc = 1'b0;
        chk("prio_pc", PC, 16'h4000);

        // Busy lockout: requests during EVAL are dropped
        NZP_val = 3'b100; IR = 16'h0803; br_start = 1'b1;
        tick();
        chk("lk_busy", {15'd0, br_busy}, 16'd1);
        pc_inc = 1'b1; pc_ld_bus = 1'b1; BUS = 16'h1234; IR = 16'h0E10;
        tick();
        br_start = 1'b0; pc_inc = 1'b0; pc_ld_bus = 1'b0;
        chk("lk_e1_pc", PC, 16'h4000);
        chk("lk_e1_done", {15'd0, br_done}, 16'd1);
        tick();
        exp_cnt = 16'd2;
        chk("lk_e2_pc", PC, 16'h4003);
        chk("lk_e2_done", {15'd0, br_done}, 16'd0);
        tick();
        chk("lk_e3_done", {15'd0, br_done}, 16'd0);
        chk("lk_e3_busy", {15'd0, br_busy}, 16'd0);
        chk("lk_e3_pc", PC, 16'h4003);
        chk_cnt("lk_cnt");

        // Offset extremes: +255 then -256
        load_pc(16'h3000);
        NZP_val = 3'b001; IR = 16'h0EFF; br_start = 1'b1;
        tick(); br_start = 1'b0; tick(); tick();
        exp_cnt = 16'd3;
        chk("max_off_pc", PC, 16'h30FF);
        IR = 16'h0F00; br_start = 1'b1;
        tick(); br_start = 1'b0; tick(); tick();
        exp_cnt = 16'd4;
        chk("min_off_pc", PC, 16'h2FFF);
        chk_cnt("off_cnt");

        // cond=000 never taken
        NZP_val = 3'b111; IR = 16'h0005; br_start = 1'b1;
        tick(); br_start = 1'b0; tick();
        chk("c0_ben", {15'd0, BEN}, 16'd0);
        tick();
        chk("c0_pc", PC, 16'h2FFF);

        // Reset in UPDATE suppresses the redirect
        NZP_val = 3'b001; IR = 16'h0E05; br_start = 1'b1;
        tick(); br_start = 1'b0; tick();
        chk("rm_ben", {15'd0, BEN}, 16'd1);
        chk("rm_done", {15'd0, br_done}, 16'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_cnt = 16'd0;
        chk("rm_pc", PC, 16'h3000);
        chk("rm_busy", {15'd0, br_busy}, 16'd0);
        chk("rm_done_off", {15'd0, br_done}, 16'd0);
        chk("rm_ben_clr", {15'd0, BEN}, 16'd0);
        chk_cnt("rm_cnt");
        tick();
        chk("rm_pc_hold", PC, 16'h3000);
        chk("rm_done_hold", {15'd0, br_done}, 16'd0);

        // NZP=000 never taken for any cond
        NZP_val = 3'b000; IR = 16'h0E05; br_start = 1'b1;
        tick(); br_start = 1'b0; tick();
        chk("z_ben", {15'd0, BEN}, 16'd0);
        tick();
        chk("z_pc", PC, 16'h3000);
        chk_cnt("z_cnt");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
